// File: rtl/i2c_master_if.sv
// Bundle of the request/status signals of the single-byte I2C master.
// Handshake: START is a request with no ready; it is taken only while the
// master is idle (BUSY low, DONE low), its operands are latched on that same
// edge, and BUSY/DONE then report progress until the transaction ends.
interface i2c_master_if;
    logic       START;
    logic [6:0] ADDR;
    logic       RW;
    logic [7:0] DATA_IN;
    logic       SCL;
    logic       BUSY;
    logic       DONE;
    logic       ACK_ERR;
    logic [7:0] DATA_RD;
    logic [2:0] DBG_STATE;

    modport master (
        input  START, ADDR, RW, DATA_IN,
        output SCL, BUSY, DONE, ACK_ERR, DATA_RD, DBG_STATE
    );

    modport slave (
        output START, ADDR, RW, DATA_IN,
        input  SCL, BUSY, DONE, ACK_ERR, DATA_RD, DBG_STATE
    );
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, {ADDR,RW}, ACK, one data byte, ACK, STOP.
// Every bus phase is four quarter-periods ("ticks") of CLK_DIV clocks each.
// SCL and the SDA pull-down are registered and computed from the next state,
// so both lines change cleanly on a clock edge. SDA is open drain and stays a
// plain inout so the wired-AND resolution happens where the pull-up lives.
module i2c_master #(
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_N,
    inout  wire          SDA,
    i2c_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_AACK  = 3'd3,
        S_DATA  = 3'd4,
        S_DACK  = 3'd5,
        S_STOP  = 3'd6
    } state_t;

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    frame_q, frame_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rd_q, rd_d;
    logic          ack_err_q, ack_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          tick;
    logic          sda_in;

    // Position inside a byte of the bit that goes on the wire n-th.
    function automatic logic [2:0] bit_idx(input logic [2:0] n);
        return LSB_FIRST ? n : (3'd7 - n);
    endfunction

    // SCL level for a given phase: high in idle/START, else high in quarters 2-3.
    function automatic logic scl_level(input state_t s, input logic [1:0] q);
        logic lvl;
        case (s)
            S_IDLE, S_START: lvl = 1'b1;
            default:         lvl = q[1];
        endcase
        return lvl;
    endfunction

    // Whether the master pulls SDA low in a given phase.
    function automatic logic sda_pull(input state_t s, input logic [1:0] q,
                                      input logic [2:0] n, input logic [7:0] f,
                                      input logic [7:0] d);
        logic pull;
        case (s)
            S_START: pull = q[1];
            S_ADDR:  pull = !f[bit_idx(n)];
            S_DATA:  pull = !f[0] && !d[bit_idx(n)];
            S_STOP:  pull = (q != 2'd3);
            default: pull = 1'b0;
        endcase
        return pull;
    endfunction

    assign sda_in = SDA;
    assign tick   = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    // Next-state, tick counter, sampling and registered line levels.
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        data_d    = data_q;
        rx_d      = rx_q;
        rd_d      = rd_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = (state_q == S_IDLE || tick) ? '0 : cnt_q + 1'b1;

        if (state_q == S_IDLE) begin
            // The DONE cycle still belongs to the finished transaction.
            if (bus.START && !done_q) begin
                frame_d   = {bus.ADDR, bus.RW};
                data_d    = bus.DATA_IN;
                rx_d      = 8'h00;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
                qtr_d     = 2'd0;
                bit_d     = 3'd0;
                state_d   = S_START;
            end
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            unique case (state_q)
                S_START: begin
                    if (qtr_q == 2'd3) begin
                        state_d = S_ADDR;
                        bit_d   = 3'd0;
                    end
                end
                S_ADDR: begin
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd7) begin
                            state_d = S_AACK;
                            bit_d   = 3'd0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                S_AACK: begin
                    if (qtr_q == 2'd2 && sda_in) begin
                        ack_err_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        // ack_err_q already holds the address-ACK sample here.
                        state_d = ack_err_q ? S_STOP : S_DATA;
                        bit_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    if (qtr_q == 2'd2 && frame_q[0]) begin
                        rx_d[bit_idx(bit_q)] = sda_in;
                        if (bit_q == 3'd7) begin
                            rd_d = rx_d;
                        end
                    end
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd7) begin
                            state_d = S_DACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                S_DACK: begin
                    // Reads end with a master NACK, so only writes check the slave.
                    if (qtr_q == 2'd2 && !frame_q[0] && sda_in) begin
                        ack_err_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (qtr_q == 2'd3) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        scl_d    = scl_level(state_d, qtr_d);
        sda_oe_d = sda_pull(state_d, qtr_d, bit_d, frame_d, data_d);
    end

    // State and line registers; reset releases both bus lines at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            frame_q   <= 8'h00;
            data_q    <= 8'h00;
            rx_q      <= 8'h00;
            rd_q      <= 8'h00;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            data_q    <= data_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign SDA           = sda_oe_q ? 1'b0 : 1'bz;
    assign bus.SCL       = scl_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ACK_ERR   = ack_err_q;
    assign bus.DATA_RD   = rd_q;
    assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: three instances (LSB-first div 4, MSB-first div 4,
// LSB-first div 1) run the same transactions against bus-level slaves.
module tb_i2c_master;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus / DUTs ----------------
    logic       start_r = 1'b0;
    logic [6:0] addr_r  = 7'h00;
    logic       rw_r    = 1'b0;
    logic [7:0] din_r   = 8'h00;

    i2c_master_if if0 ();
    i2c_master_if if1 ();
    i2c_master_if if2 ();

    wire sda0, sda1, sda2;
    pullup (sda0);
    pullup (sda1);
    pullup (sda2);

    logic slv_low [3] = '{1'b0, 1'b0, 1'b0};
    assign sda0 = slv_low[0] ? 1'b0 : 1'bz;
    assign sda1 = slv_low[1] ? 1'b0 : 1'bz;
    assign sda2 = slv_low[2] ? 1'b0 : 1'bz;

    assign if0.START = start_r;  assign if0.ADDR = addr_r;  assign if0.RW = rw_r;  assign if0.DATA_IN = din_r;
    assign if1.START = start_r;  assign if1.ADDR = addr_r;  assign if1.RW = rw_r;  assign if1.DATA_IN = din_r;
    assign if2.START = start_r;  assign if2.ADDR = addr_r;  assign if2.RW = rw_r;  assign if2.DATA_IN = din_r;

    i2c_master #(.CLK_DIV(4), .LSB_FIRST(1'b1)) dut0 (.CLK(clk), .RST_N(rst_n), .SDA(sda0), .bus(if0.master));
    i2c_master #(.CLK_DIV(4), .LSB_FIRST(1'b0)) dut1 (.CLK(clk), .RST_N(rst_n), .SDA(sda1), .bus(if1.master));
    i2c_master #(.CLK_DIV(1), .LSB_FIRST(1'b1)) dut2 (.CLK(clk), .RST_N(rst_n), .SDA(sda2), .bus(if2.master));

    logic       scl_v [3];
    logic       sda_v [3];
    logic       done_v[3];
    logic       busy_v[3];
    logic       err_v [3];
    logic [7:0] rd_v  [3];
    assign scl_v[0] = if0.SCL;  assign sda_v[0] = sda0;  assign done_v[0] = if0.DONE;
    assign scl_v[1] = if1.SCL;  assign sda_v[1] = sda1;  assign done_v[1] = if1.DONE;
    assign scl_v[2] = if2.SCL;  assign sda_v[2] = sda2;  assign done_v[2] = if2.DONE;
    assign busy_v[0] = if0.BUSY;  assign err_v[0] = if0.ACK_ERR;  assign rd_v[0] = if0.DATA_RD;
    assign busy_v[1] = if1.BUSY;  assign err_v[1] = if1.ACK_ERR;  assign rd_v[1] = if1.DATA_RD;
    assign busy_v[2] = if2.BUSY;  assign err_v[2] = if2.ACK_ERR;  assign rd_v[2] = if2.DATA_RD;

    function automatic int div_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit lsb_of(input int k);
        return (k != 1);
    endfunction

    // ---------------- bus-level slave and monitor ----------------
    logic       cfg_ack_a = 1'b1;
    logic       cfg_ack_d = 1'b1;
    logic       cfg_rw    = 1'b0;
    logic [7:0] cfg_rd    = 8'h00;

    logic prev_scl [3];
    logic prev_sda [3];
    int   nrise    [3];
    logic rec_b    [3][32];
    int   rec_n    [3];
    int   start_cnt[3] = '{0, 0, 0};
    int   stop_cnt [3] = '{0, 0, 0};

    // Level the slave puts on SDA for the p-th SCL high pulse after START.
    function automatic logic slave_pull(input int p, input bit lsb);
        if (p == 9) return cfg_ack_a;
        if (p >= 10 && p <= 17) return cfg_ack_a && cfg_rw && !cfg_rd[lsb ? (p - 10) : (17 - p)];
        if (p == 18) return cfg_ack_a && !cfg_rw && cfg_ack_d;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                nrise[k]    = 0;
                slv_low[k]  = 1'b0;
                prev_scl[k] = 1'b1;
                prev_sda[k] = 1'b1;
            end else begin
                if (prev_scl[k] && scl_v[k] && prev_sda[k] && !sda_v[k]) begin
                    start_cnt[k]++;
                    nrise[k] = 0;
                    rec_n[k] = 0;
                end
                if (prev_scl[k] && scl_v[k] && !prev_sda[k] && sda_v[k]) stop_cnt[k]++;
                if (!prev_scl[k] && scl_v[k]) begin
                    nrise[k]++;
                    if (rec_n[k] < 32) begin
                        rec_b[k][rec_n[k]] = sda_v[k];
                        rec_n[k]++;
                    end
                end
                if (prev_scl[k] && !scl_v[k]) slv_low[k] = slave_pull(nrise[k] + 1, lsb_of(k));
                prev_scl[k] = scl_v[k];
                prev_sda[k] = sda_v[k];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    int   t0;
    int   lat      [3];
    int   done_hits[3];
    int   st0      [3];
    int   sp0      [3];
    logic [7:0] model_rd = 8'h00;

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h", name, k, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [6:0] a, input logic rw, input logic [7:0] d,
                          input logic aa, input logic ad, input logic [7:0] rb);
        @(negedge clk);
        cfg_ack_a = aa;  cfg_ack_d = ad;  cfg_rw = rw;  cfg_rd = rb;
        addr_r = a;  rw_r = rw;  din_r = d;  start_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st0[k] = start_cnt[k];  sp0[k] = stop_cnt[k];
            lat[k] = -1;  done_hits[k] = 0;
        end
        t0 = cyc;
        @(negedge clk);
        start_r = 1'b0;
        // Scramble operands: they must already be latched.
        addr_r = 7'($urandom);  din_r = 8'($urandom);  rw_r = 1'($urandom);
        for (int k = 0; k < 3; k++) chk("busy_after_accept", k, 32'(busy_v[k]), 32'd1);
    endtask

    task automatic finish_txn(input int glitch_at);
        int settle;
        settle = 0;
        for (int n = 0; n < 3000; n++) begin
            start_r = (n == glitch_at);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done_v[k]) begin
                    done_hits[k]++;
                    if (lat[k] < 0) lat[k] = cyc - t0 - 1;
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) begin
                settle++;
                if (settle > 2) break;
            end
        end
        start_r = 1'b0;
    endtask

    // Expected SDA levels at each SCL rise, built from the transaction rules.
    task automatic verify(input logic [6:0] a, input logic rw, input logic [7:0] d,
                          input logic aa, input logic ad, input logic [7:0] rb,
                          input logic exp_err, input logic [7:0] exp_rd, input int ticks);
        logic [7:0]  f;
        logic [7:0]  byte_on_wire;
        logic [31:0] gv, ev;
        for (int k = 0; k < 3; k++) begin
            f = {a, rw};
            byte_on_wire = rw ? rb : d;
            exp_q.delete();
            for (int i = 0; i < 8; i++) exp_q.push_back(f[lsb_of(k) ? i : 7 - i]);
            exp_q.push_back(!aa);
            if (aa) begin
                for (int i = 0; i < 8; i++) exp_q.push_back(byte_on_wire[lsb_of(k) ? i : 7 - i]);
                exp_q.push_back(rw ? 1'b1 : !ad);
            end
            exp_q.push_back(1'b0);
            gv = '0;  ev = '0;
            for (int i = 0; i < rec_n[k] && i < 32; i++) gv[i] = rec_b[k][i];
            for (int i = 0; i < exp_q.size(); i++) ev[i] = exp_q[i];
            chk("scl_pulse_count", k, 32'(rec_n[k]), 32'(exp_q.size()));
            chk("bit_stream", k, gv, ev);
            chk("latency", k, 32'(lat[k]), 32'(ticks * div_of(k)));
            chk("done_pulses", k, 32'(done_hits[k]), 32'd1);
            chk("busy_end", k, 32'(busy_v[k]), 32'd0);
            chk("ack_err", k, 32'(err_v[k]), 32'(exp_err));
            chk("data_rd", k, 32'(rd_v[k]), 32'(exp_rd));
            chk("start_cond", k, 32'(start_cnt[k] - st0[k]), 32'd1);
            chk("stop_cond", k, 32'(stop_cnt[k] - sp0[k]), 32'd1);
        end
    endtask

    function automatic logic [7:0] rec_byte(input int k, input int from);
        logic [7:0] v;
        v = 8'h00;
        for (int j = 0; j < 8; j++) v = {v[6:0], rec_b[k][from + j]};
        return v;
    endfunction

    task automatic check_reset_state(input string name);
        for (int k = 0; k < 3; k++) begin
            chk({name, "_scl"}, k, 32'(scl_v[k]), 32'd1);
            chk({name, "_sda"}, k, 32'(sda_v[k]), 32'd1);
            chk({name, "_busy"}, k, 32'(busy_v[k]), 32'd0);
            chk({name, "_done"}, k, 32'(done_v[k]), 32'd0);
            chk({name, "_ack_err"}, k, 32'(err_v[k]), 32'd0);
            chk({name, "_data_rd"}, k, 32'(rd_v[k]), 32'd0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] din;
        logic       ack_a;
        logic       ack_d;
        logic [7:0] rd_byte;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_ticks;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [6:0] a;
        logic       rw, aa, ad;
        logic [7:0] d, rb;
        logic       e_err;

        tbl[0] = '{7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 80};  // write, acked
        tbl[1] = '{7'h19, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 44};  // address NACK
        tbl[2] = '{7'h19, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 80};  // read 3C
        tbl[3] = '{7'h55, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 80};  // data NACK
        tbl[4] = '{7'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h3C, 44};  // read, address NACK
        tbl[5] = '{7'h00, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 8'h81, 80};  // read 81

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].addr, tbl[i].rw, tbl[i].din, tbl[i].ack_a, tbl[i].ack_d, tbl[i].rd_byte);
            finish_txn(-1);
            verify(tbl[i].addr, tbl[i].rw, tbl[i].din, tbl[i].ack_a, tbl[i].ack_d, tbl[i].rd_byte,
                   tbl[i].exp_err, tbl[i].exp_rd, tbl[i].exp_ticks);
            if (i == 0) begin
                chk("t2_addr_bits", 0, 32'(rec_byte(0, 0)), 32'h4C);  // 0,1,0,0,1,1,0,0
                chk("t6_addr_bits", 1, 32'(rec_byte(1, 0)), 32'h32);  // 0,0,1,1,0,0,1,0
                chk("t2_data_bits", 0, 32'(rec_byte(0, 9)), 32'hA5);  // 1,0,1,0,0,1,0,1
                chk("t6_data_bits", 1, 32'(rec_byte(1, 9)), 32'hA5);
            end
        end
        model_rd = 8'h81;

        // START pulse while busy is ignored.
        launch(7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        finish_txn(40);
        verify(7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, model_rd, 80);

        // Randomized transactions against the model.
        for (int r = 0; r < 16; r++) begin
            a  = 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            aa = ($urandom_range(0, 3) != 0);
            ad = ($urandom_range(0, 3) != 0);
            rb = 8'($urandom_range(0, 255));
            e_err = !aa || (!rw && !ad);
            if (rw && aa) model_rd = rb;
            launch(a, rw, d, aa, ad, rb);
            finish_txn(-1);
            verify(a, rw, d, aa, ad, rb, e_err, model_rd, aa ? 80 : 44);
        end

        // Reset during data bit 3, then a clean write.
        launch(7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        repeat (209) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("mid_data_reset_busy", k, 32'(busy_v[k]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_rd = 8'h00;
        @(negedge clk);
        launch(7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        finish_txn(-1);
        verify(7'h19, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 80);
        chk("t5_addr_bits", 0, 32'(rec_byte(0, 0)), 32'h4C);

        // Read so DATA_RD is non-zero, then reset mid-STOP of a data-NACK write.
        launch(7'h19, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
        finish_txn(-1);
        verify(7'h19, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 80);
        launch(7'h19, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00);
        repeat (308) @(negedge clk);
        chk("pre_reset_scl_low", 0, 32'(scl_v[0]), 32'd0);
        chk("pre_reset_sda_low", 0, 32'(sda_v[0]), 32'd0);
        chk("pre_reset_ack_err", 0, 32'(err_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("stop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
